key_inv_schedule: RTL
=====================

Name: key_inv_schedule

Overview:
- Sequential AES-256 inverse key schedule for the decrypt datapath.
- Loaded with the last 256 bits of the forward schedule, words w52..w59 (round keys RK13 and RK14).
- Regenerates the schedule backwards and streams RK14, RK13, ..., RK0 one 128-bit key per handshake, in the order the decrypt rounds consume them.
- Replaces a full 15-key combinational store with one 256-bit window register and 8 S-boxes.

Parameters:
None. AES-256 only: Nr=14, Nk=8, 15 round keys.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle load request; accepted only in IDLE
last_key  in  256  {w52,w53,...,w59}; w52 at bits [255:224], w59 at bits [31:0]
rk_valid  out  1  round key available on rk_data
rk_ready  in  1  consumer accepts rk_data this cycle
rk_data  out  128  current round key, lowest-numbered word at MSBs
rk_index  out  4  round number of rk_data, 14 down to 0
busy  out  1  high from start acceptance until the RK0 handshake
done  out  1  one-cycle pulse in the cycle after the RK0 handshake

Behaviour:
- Reset values: window=0, rk_valid=0, rk_data=0, rk_index=0, busy=0, done=0, state=IDLE.
- Window register holds 8 consecutive words w[m..m+7]. Initial m=52; m decreases by 8 per inverse step.
- Emission half:
  - LO half (bits [127:0], w[m+4..m+7]) carries the even round key.
  - HI half (bits [255:128], w[m..m+3]) carries the odd round key.
- Inverse step (combinational, sub-module), for n = m+7 down to m: w[n-8] = w[n] ^ f_n(w[n-1]).
  - f_n = SubWord(RotWord(x)) ^ Rcon[n/8] when n%8==0.
  - f_n = SubWord(x) when n%8==4.
  - f_n = identity otherwise.
  - w[m-1] is recovered first and feeds the n=m term; the chain is sequential inside one cycle.
  - Step k (m=8k+4, k=6..0) uses Rcon[k+1] and Sub at n=m. Rcon index therefore goes 7..1.
- States:
  - IDLE → EMIT_LO on start: window<=last_key, rk_index<=14, busy<=1, rk_valid<=1.
  - EMIT_LO, on handshake (rk_valid&rk_ready):
    - if rk_index==0 → IDLE, rk_valid<=0, busy<=0, done<=1;
    - else rk_index--, → EMIT_HI.
  - EMIT_HI, on handshake: window<=inverse_step(window), rk_index--, → EMIT_LO.
- rk_data is registered: it selects the half for the current state from the registered window. No combinational path from rk_ready to rk_data.
- Throughput and latency:
  - rk_valid rises the cycle after start.
  - One key per cycle while rk_ready=1; RK0 handshake ≥15 cycles after start.
- Backpressure: while rk_valid&!rk_ready, rk_data, rk_index and window are held stable.
- After the final step (window w[-4..3]) only the LO half is meaningful. The HI half is don't-care and is never emitted.
- start while busy: ignored, with no effect on state or outputs.
- start and RK0 handshake in the same cycle: start ignored; done pulses; the next start is accepted from IDLE.
- rst asserted mid-sequence: all registers return to reset values immediately. No partial key is emitted after deassertion.
- rk_ready while rk_valid=0: ignored.

Decomposition:
- aes_pkg holds:
  - typedef word_t (logic [31:0]);
  - S-box function sbox(byte);
  - functions sub_word, rot_word;
  - RCON constant array, index 1..7 (01,02,04,08,10,20,40 in the MSB byte).
- Sub-module key_inv_step (combinational) takes window_in[255:0] and rcon_idx[2:0] and produces window_out[255:0]. It instantiates 8 S-boxes: 4 for n%8==0, 4 for n%8==4.
- FSM, counters and handshake live in key_inv_schedule.

Test Plan:
- FIPS-197 AES-256 key 000102..1f: last_key = 4e5a6699a9f24fe07e572baacdf8cdea_24fc79ccbf0979e9371ac23c6d68de36, rk_ready=1 → rk_data sequence:
  - rk_index 14: 24fc79ccbf0979e9371ac23c6d68de36
  - rk_index 13: 4e5a6699a9f24fe07e572baacdf8cdea
  - rk_index 1: 101112131415161718191a1b1c1d1e1f
  - rk_index 0: 000102030405060708090a0b0c0d0e0f
  - done pulses once, cycle 16 after start.
- Round-trip: 20 random 256-bit user keys through key_expansion; feed {round6 lower half, round7} as last_key → all 15 emitted keys match the forward schedule in reverse.
- Backpressure: rk_ready toggled randomly, plus held low 5 cycles on rk_index 8 → rk_data/rk_index stable, no key skipped or duplicated, 15 handshakes total.
- start pulsed at rk_index 9 with a different last_key → ignored; sequence completes with the original keys.
- rst asserted while rk_index=6, then start with vector 1 → all outputs 0 during reset; fresh sequence begins at rk_index 14 with correct keys.
- start asserted in the same cycle as the RK0 handshake, then again 1 cycle later → first start ignored, done=1; second start accepted, rk_valid=1 the next cycle with rk_index=14.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-256 key-schedule helpers shared by the inverse key schedule:
// word type, S-box lookup, SubWord/RotWord and round constants.
package aes_pkg;

    typedef logic [31:0] word_t;

    // Inverse key schedule sequencer states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StEmitLo = 2'd1,
        StEmitHi = 2'd2
    } sched_state_e;

    // Round number of the first key streamed out (AES-256, Nr = 14).
    localparam logic [3:0] LAST_RK_IDX = 4'd14;

    // Forward S-box, byte 0x00 in the top byte, 0xff in the bottom byte.
    localparam logic [2047:0] SBOX_VEC = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants; entry 0 is unused, 1..7 are the ones AES-256 needs.
    localparam word_t RCON [8] = '{
        32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0400_0000,
        32'h0800_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Byte b sits at offset (255 - b) * 8 == {~b, 3'b000}.
        return SBOX_VEC[{~b, 3'b000} +: 8];
    endfunction

    function automatic word_t sub_word(input word_t x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t x);
        return {x[23:0], x[31:24]};
    endfunction

endpackage

// File: rtl/key_inv_step.sv
// One backward step of the AES-256 key schedule: window w[m..m+7] in,
// window w[m-8..m-1] out. Purely combinational, 8 S-boxes.
module key_inv_step
    import aes_pkg::*;
(
    input  logic [255:0] window_in,
    input  logic [2:0]   rcon_idx,
    output logic [255:0] window_out
);

    word_t w_src [8];   // w_src[i] = w[m+i]
    word_t w_dst [8];   // w_dst[i] = w[m-8+i]
    word_t w_sub_rot;   // SubWord(RotWord(w[m+3])) ^ Rcon, for n = m+4
    word_t w_last;      // w[m-1], recovered first
    word_t w_sub;       // SubWord(w[m-1]), for n = m

    // Split the window into words, w[m] at the MSBs.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_src[i] = window_in[255 - 32 * i -: 32];
        end
    end

    // S-box terms: the rotated one uses w[m+3], the plain one needs w[m-1].
    always_comb begin
        w_last    = w_src[7] ^ w_src[6];
        w_sub_rot = sub_word(rot_word(w_src[3])) ^ RCON[rcon_idx];
        w_sub     = sub_word(w_last);
    end

    // w[n-8] = w[n] ^ f_n(w[n-1]) for n = m+7 down to m.
    always_comb begin
        w_dst[7] = w_last;
        w_dst[6] = w_src[6] ^ w_src[5];
        w_dst[5] = w_src[5] ^ w_src[4];
        w_dst[4] = w_src[4] ^ w_sub_rot;
        w_dst[3] = w_src[3] ^ w_src[2];
        w_dst[2] = w_src[2] ^ w_src[1];
        w_dst[1] = w_src[1] ^ w_src[0];
        w_dst[0] = w_src[0] ^ w_sub;
    end

    // Reassemble, lowest-numbered word at the MSBs.
    always_comb begin
        window_out = {w_dst[0], w_dst[1], w_dst[2], w_dst[3],
                      w_dst[4], w_dst[5], w_dst[6], w_dst[7]};
    end

endmodule

// File: rtl/key_inv_schedule.sv
// Sequential AES-256 inverse key schedule. Loaded with w52..w59, it streams
// RK14 down to RK0 over a valid/ready handshake, rebuilding earlier words
// with one 256-bit window and a single inverse step per two keys.
module key_inv_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] last_key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         busy,
    output logic         done
);

    sched_state_e r_state;
    sched_state_e w_state_nxt;

    logic [255:0] r_window;
    logic [255:0] w_window_nxt;
    logic [127:0] r_rk_data;
    logic [127:0] w_rk_data_nxt;
    logic [3:0]   r_rk_index;
    logic [3:0]   w_rk_index_nxt;
    logic         r_rk_valid;
    logic         w_rk_valid_nxt;
    logic         r_busy;
    logic         w_busy_nxt;
    logic         r_done;
    logic         w_done_nxt;

    logic         w_handshake;
    logic [2:0]   w_rcon_idx;
    logic [255:0] w_step_window;

    assign w_handshake = r_rk_valid & rk_ready;
    // In EmitHi the index is odd (13..1); step k = index/2 uses Rcon[k+1].
    assign w_rcon_idx  = r_rk_index[3:1] + 3'd1;

    key_inv_step u_step (
        .window_in  (r_window),
        .rcon_idx   (w_rcon_idx),
        .window_out (w_step_window)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window   <= '0;
            r_rk_data  <= '0;
            r_rk_index <= '0;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_window   <= w_window_nxt;
            r_rk_data  <= w_rk_data_nxt;
            r_rk_index <= w_rk_index_nxt;
            r_rk_valid <= w_rk_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state logic; everything holds unless a load or handshake moves it.
    always_comb begin
        w_state_nxt    = r_state;
        w_window_nxt   = r_window;
        w_rk_data_nxt  = r_rk_data;
        w_rk_index_nxt = r_rk_index;
        w_rk_valid_nxt = r_rk_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_window_nxt   = last_key;
                    w_rk_data_nxt  = last_key[127:0];
                    w_rk_index_nxt = LAST_RK_IDX;
                    w_rk_valid_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = StEmitLo;
                end
            end
            StEmitLo: begin
                if (w_handshake) begin
                    if (r_rk_index == 4'd0) begin
                        w_rk_valid_nxt = 1'b0;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_state_nxt    = StIdle;
                    end else begin
                        w_rk_index_nxt = r_rk_index - 4'd1;
                        w_rk_data_nxt  = r_window[255:128];
                        w_state_nxt    = StEmitHi;
                    end
                end
            end
            StEmitHi: begin
                if (w_handshake) begin
                    w_window_nxt   = w_step_window;
                    w_rk_data_nxt  = w_step_window[127:0];
                    w_rk_index_nxt = r_rk_index - 4'd1;
                    w_state_nxt    = StEmitLo;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign rk_valid = r_rk_valid;
    assign rk_data  = r_rk_data;
    assign rk_index = r_rk_index;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
